adder_mul_sequencer: RTL and testbench

//  Multi-cycle shift-and-add multiply controller that time-shares one external
//  18-bit ripple adder (SRC1/SRC2/Output, no carry-in/out) to form a truncated product.

---
 rtl/adder_mul_sequencer.sv | 116 +++++++++++
 tb/tb_adder_mul_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/adder_mul_sequencer.sv
// Shift-and-add multiply controller driving a shared external WIDTH-bit adder.
// Produces the low WIDTH bits of op_a*op_b, optionally stopping once no multiplier bits remain.
module adder_mul_sequencer #(
    parameter int WIDTH      = 18,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] add_src1,
    output logic [WIDTH-1:0] add_src2,
    input  logic [WIDTH-1:0] add_sum
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             last_run;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        add_src1  = '0;
        add_src2  = '0;
        last_run  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                add_src1 = acc_q;
                add_src2 = mcand_q;
                if (mplier_q[0]) begin
                    acc_d = add_sum;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // The WIDTH-1 count exit is unconditional so cnt can never wrap.
                last_run = (cnt_q == CW'(WIDTH - 1)) ||
                           (EARLY_EXIT && (mplier_q[WIDTH-1:1] == '0));
                if (last_run) begin
                    product_d = mplier_q[0] ? add_sum : acc_q;
                    cnt_d     = cnt_q;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
endmodule

// File: tb/tb_adder_mul_sequencer.sv
// Directed bench for adder_mul_sequencer: one early-exit instance, one full-length instance,
// each wired to its own behavioural ripple adder.
module tb_adder_mul_sequencer;
    logic        clk;
    logic        rst;
    logic        start1, start0;
    logic [17:0] a1, b1, a0, b0;
    logic        busy1, done1, busy0, done0;
    logic [17:0] prod1, prod0;
    logic [17:0] s1_1, s2_1, sum1, s1_0, s2_0, sum0;

    logic        sel;
    logic        o_busy, o_done;
    logic [17:0] o_prod;

    int n_cmp = 0;
    int n_err = 0;

    assign sum1 = s1_1 + s2_1;
    assign sum0 = s1_0 + s2_0;

    assign o_busy = sel ? busy1 : busy0;
    assign o_done = sel ? done1 : done0;
    assign o_prod = sel ? prod1 : prod0;

    adder_mul_sequencer #(.WIDTH(18), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op_a(a1), .op_b(b1),
        .busy(busy1), .done(done1), .product(prod1),
        .add_src1(s1_1), .add_src2(s2_1), .add_sum(sum1)
    );

    adder_mul_sequencer #(.WIDTH(18), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .op_a(a0), .op_b(b0),
        .busy(busy0), .done(done0), .product(prod0),
        .add_src1(s1_0), .add_src2(s2_0), .add_sum(sum0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s, input logic st, input logic [17:0] a, input logic [17:0] b);
        if (s) begin
            start1 = st; a1 = a; b1 = b;
        end else begin
            start0 = st; a0 = a; b0 = b;
        end
    endtask

    // Start one op, optionally re-pulse start with other operands in RUN cycle pulse_at.
    task automatic run_op(input bit s, input logic [17:0] a, input logic [17:0] b,
                          input int exp_n, input logic [17:0] exp_p,
                          input string tag, input int pulse_at);
        int n;
        int busy_gap;
        sel = s;
        @(negedge clk);
        drive(s, 1'b1, a, b);
        @(negedge clk);
        drive(s, 1'b0, 18'h0, 18'h0);
        n = 1;
        busy_gap = 0;
        while (o_done !== 1'b1 && n < 60) begin
            if (o_busy !== 1'b1) busy_gap++;
            if (n == pulse_at) drive(s, 1'b1, 18'h3FFFF, 18'h3FFFF);
            @(negedge clk);
            drive(s, 1'b0, 18'h0, 18'h0);
            n++;
        end
        check({tag, "_done_cycle"}, n, exp_n + 1);
        check({tag, "_product"}, o_prod, exp_p);
        check({tag, "_busy_at_done"}, o_busy, 1'b1);
        check({tag, "_busy_gaps"}, busy_gap, 0);
        @(negedge clk);
        check({tag, "_done_single"}, o_done, 1'b0);
        check({tag, "_busy_after"}, o_busy, 1'b0);
        check({tag, "_product_hold"}, o_prod, exp_p);
    endtask

    initial begin
        logic [17:0] m_acc, m_mc, m_mp;
        rst = 1'b1;
        sel = 1'b1;
        start1 = 1'b0; start0 = 1'b0;
        a1 = '0; b1 = '0; a0 = '0; b0 = '0;
        #12;
        check("rst_busy", busy1, 1'b0);
        check("rst_done", done1, 1'b0);
        check("rst_product", prod1, 18'h0);
        check("rst_src1", s1_1, 18'h0);
        check("rst_src2", s2_1, 18'h0);
        @(negedge clk);
        rst = 1'b0;

        // 1: 5*7 early exit
        run_op(1'b1, 18'd5, 18'd7, 3, 18'h00023, "t1_5x7", 0);
        // 2: all ones squared
        run_op(1'b1, 18'h3FFFF, 18'h3FFFF, 18, 18'h00001, "t2_ones", 0);
        // 3: zero multiplier, both exit modes
        run_op(1'b1, 18'h12345, 18'h0, 1, 18'h0, "t3_zero_ee1", 0);
        run_op(1'b0, 18'h12345, 18'h0, 18, 18'h0, "t3_zero_ee0", 0);
        run_op(1'b0, 18'd5, 18'd7, 18, 18'h00023, "t3_5x7_ee0", 0);

        // 4: truncation with per-cycle adder operand trace
        sel = 1'b1;
        @(negedge clk);
        check("t4_idle_src1", s1_1, 18'h0);
        check("t4_idle_src2", s2_1, 18'h0);
        drive(1'b1, 1'b1, 18'h00003, 18'h20000);
        @(negedge clk);
        drive(1'b1, 1'b0, 18'h0, 18'h0);
        m_acc = '0; m_mc = 18'h00003; m_mp = 18'h20000;
        for (int i = 0; i < 18; i++) begin
            check($sformatf("t4_src1_c%0d", i + 1), s1_1, m_acc);
            check($sformatf("t4_src2_c%0d", i + 1), s2_1, m_mc);
            if (m_mp[0]) m_acc = m_acc + m_mc;
            m_mc = m_mc << 1;
            m_mp = m_mp >> 1;
            @(negedge clk);
        end
        check("t4_done", done1, 1'b1);
        check("t4_product", prod1, 18'h20000);
        check("t4_done_src1", s1_1, 18'h0);
        check("t4_done_src2", s2_1, 18'h0);
        // start raised during DONE must be ignored; the following IDLE cycle accepts it
        drive(1'b1, 1'b1, 18'd5, 18'd7);
        @(negedge clk);
        check("t4_b2b_idle_busy", busy1, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 18'h0, 18'h0);
        check("t4_b2b_accepted", busy1, 1'b1);
        repeat (3) @(negedge clk);
        check("t4_b2b_product", prod1, 18'h00023);
        check("t4_b2b_done", done1, 1'b1);

        // 5: start during RUN is ignored (0x11*0xF0, 8 RUN cycles)
        run_op(1'b1, 18'h00011, 18'h000F0, 8, 18'h00FF0, "t5_ignore", 2);

        // 6: async reset in RUN cycle 5 of 18
        sel = 1'b1;
        @(negedge clk);
        drive(1'b1, 1'b1, 18'h3FFFF, 18'h3FFFF);
        @(negedge clk);
        drive(1'b1, 1'b0, 18'h0, 18'h0);
        repeat (4) @(negedge clk);
        check("t6_busy_pre", busy1, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_busy", busy1, 1'b0);
        check("t6_rst_done", done1, 1'b0);
        check("t6_rst_product", prod1, 18'h0);
        check("t6_rst_src1", s1_1, 18'h0);
        check("t6_rst_src2", s2_1, 18'h0);
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b1, 18'd5, 18'd7, 3, 18'h00023, "t6_after_rst", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
